// File: rtl/noc_pe_interface.sv
// PE network interface: host TX/RX channels to and from a mesh router PE port.
// Latency 1 cycle each way; TX backpressures via s_ready, RX drops flits when its FIFO is full.

module noc_pe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Storage is not reset, so the head is masked to zero while empty.
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

module noc_pe_interface #(
    parameter int X           = 4,
    parameter int Y           = 4,
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int data_width  = 256,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int total_width = x_size + y_size + data_width,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [data_width-1:0]  s_data,
    input  logic [x_size-1:0]      s_dest_x,
    input  logic [y_size-1:0]      s_dest_y,
    output logic                   o_valid,
    output logic [total_width-1:0] o_data,
    input  logic                   i_ready,
    input  logic                   i_valid,
    input  logic [total_width-1:0] i_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [data_width-1:0]  m_data,
    output logic                   rx_overflow,
    output logic                   misroute,
    output logic [15:0]            tx_count,
    output logic [15:0]            rx_count,
    output logic [15:0]            drop_count
);
    localparam logic [x_size-1:0] LP_OWN_X = x_size'(x_coord);
    localparam logic [y_size-1:0] LP_OWN_Y = y_size'(y_coord);

    logic                   w_tx_empty;
    logic                   w_tx_full;
    logic                   w_tx_push;
    logic                   w_tx_pop;
    logic [total_width-1:0] w_tx_flit;

    logic                   w_rx_empty;
    logic                   w_rx_full;
    logic                   w_rx_push;
    logic                   w_rx_pop;
    logic                   w_rx_drop;
    logic [x_size-1:0]      w_rx_x;
    logic [y_size-1:0]      w_rx_y;
    logic                   w_rx_misroute;

    logic                   r_rx_overflow;
    logic                   r_misroute;
    logic [15:0]            r_tx_count;
    logic [15:0]            r_rx_count;
    logic [15:0]            r_drop_count;

    // rstn gates s_ready so it is low during reset and high on the first cycle after release.
    assign s_ready   = rstn && !w_tx_full;
    assign w_tx_push = s_valid && s_ready;
    assign w_tx_flit = {s_dest_y, s_dest_x, s_data};
    assign o_valid   = !w_tx_empty;
    assign w_tx_pop  = o_valid && i_ready;

    noc_pe_fifo #(
        .WIDTH (total_width),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_tx_push),
        .i_push_dat (w_tx_flit),
        .i_pop      (w_tx_pop),
        .o_head_dat (o_data),
        .o_empty    (w_tx_empty),
        .o_full     (w_tx_full)
    );

    // A full RX FIFO still accepts a flit when the host pops in the same cycle.
    assign m_valid   = !w_rx_empty;
    assign w_rx_pop  = m_valid && m_ready;
    assign w_rx_push = i_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_drop = i_valid && w_rx_full && !w_rx_pop;

    assign w_rx_x        = i_data[data_width +: x_size];
    assign w_rx_y        = i_data[data_width + x_size +: y_size];
    assign w_rx_misroute = (w_rx_x != LP_OWN_X) || (w_rx_y != LP_OWN_Y) ||
                           (int'(w_rx_x) >= X) || (int'(w_rx_y) >= Y);

    noc_pe_fifo #(
        .WIDTH (data_width),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_rx_push),
        .i_push_dat (i_data[data_width-1:0]),
        .i_pop      (w_rx_pop),
        .o_head_dat (m_data),
        .o_empty    (w_rx_empty),
        .o_full     (w_rx_full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_overflow <= 1'b0;
            r_misroute    <= 1'b0;
            r_tx_count    <= '0;
            r_rx_count    <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_rx_drop)                 r_rx_overflow <= 1'b1;
            if (i_valid && w_rx_misroute)  r_misroute    <= 1'b1;
            if (w_tx_pop)                  r_tx_count    <= r_tx_count + 16'd1;
            if (w_rx_push)                 r_rx_count    <= r_rx_count + 16'd1;
            if (w_rx_drop && (r_drop_count != 16'hFFFF))
                r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign rx_overflow = r_rx_overflow;
    assign misroute    = r_misroute;
    assign tx_count    = r_tx_count;
    assign rx_count    = r_rx_count;
    assign drop_count  = r_drop_count;
endmodule

// File: doc/noc_pe_interface.md
NOC_PE_INTERFACE -- requirements
Module: noc_pe_interface

Interface
REQ-001 SHALL have parameter X, default 4: mesh columns.
REQ-002 SHALL have parameter Y, default 4: mesh rows.
REQ-003 SHALL have parameter x_coord, default 0: own column.
REQ-004 SHALL have parameter y_coord, default 0: own row.
REQ-005 SHALL have parameter data_width, default 256: payload bits.
REQ-006 SHALL have parameters x_size and y_size, default 2 each: destination field widths.
REQ-007 SHALL have parameter total_width, default x_size+y_size+data_width: flit width.
REQ-008 SHALL have parameters TX_DEPTH and RX_DEPTH, default 4 each: FIFO entries; power of two, 2 or more.
REQ-009 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-010 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-011 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, data_width), s_dest_x (input, x_size), s_dest_y (input, y_size): host send channel.
REQ-012 SHALL have ports o_valid (output, 1), o_data (output, total_width), i_ready (input, 1): injection into the router PE port.
REQ-013 SHALL have ports i_valid (input, 1), i_data (input, total_width): ejection from the router PE port; this channel has no backpressure.
REQ-014 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, data_width): host receive channel.
REQ-015 SHALL have ports rx_overflow (output, 1), misroute (output, 1), tx_count (output, 16), rx_count (output, 16), drop_count (output, 16): status outputs.

Function
REQ-016 Flit format SHALL be {dest_y, dest_x, data}: y in the y_size MSBs, x in the next x_size bits, payload in the data_width LSBs.
REQ-017 s_ready SHALL equal "TX FIFO not full"; a push SHALL occur when s_valid and s_ready are both high.
REQ-018 A push accepted in cycle N into an empty TX FIFO SHALL produce o_valid high at N+1, with o_data = {s_dest_y, s_dest_x, s_data}.
REQ-019 Once high, o_valid and o_data SHALL hold stable until i_ready is sampled high; a flit SHALL pop when o_valid and i_ready are both high.
REQ-020 The TX FIFO SHALL preserve order, accept push and pop in the same cycle when not full, and wrap pointers modulo TX_DEPTH.
REQ-021 When i_valid is high and the RX FIFO is not full, or is full with a pop in the same cycle, the payload SHALL be written; m_valid SHALL rise the next cycle.
REQ-022 When i_valid is high, the RX FIFO is full and no pop occurs, the flit SHALL be discarded; rx_overflow SHALL set (sticky) and drop_count SHALL increment.
REQ-023 m_valid and m_data SHALL hold until m_ready; an RX pop SHALL occur when m_valid and m_ready are both high.
REQ-024 If i_valid is high and the received dest fields differ from (x_coord, y_coord), misroute SHALL set (sticky); the payload SHALL still be handled per REQ-021/022.
REQ-025 tx_count SHALL increment per injection handshake and rx_count per RX write; both SHALL wrap from 0xFFFF to 0. drop_count SHALL saturate at 0xFFFF.
REQ-026 TX and RX paths SHALL operate independently and concurrently every cycle.

Reset
REQ-027 While rstn is low: s_ready=0, o_valid=0, m_valid=0, o_data=0, m_data=0, all flags and counters 0, FIFOs empty.
REQ-028 The first cycle after rstn deassertion SHALL have s_ready=1.
REQ-029 Reset asserted mid-transfer SHALL discard all FIFO contents with no partial flit emitted.

Verification
REQ-030 Single send: dest (2,1), data 0xA5, i_ready=1 -> o_valid one cycle after the handshake, o_data={1,2,0xA5}, tx_count=1.
REQ-031 TX backpressure: i_ready=0, 5 pushes with TX_DEPTH=4 -> s_ready=0 after 4 pushes, o_data stable; release i_ready -> 4 flits in order.
REQ-032 RX overflow: m_ready=0, 6 i_valid flits with RX_DEPTH=4 -> 4 stored, drop_count=2, rx_overflow=1, first 4 payloads delivered in order.
REQ-033 Full RX with m_ready=1 and i_valid in the same cycle -> no drop, occupancy unchanged, drop_count unchanged.
REQ-034 Misroute: node (1,1) receives dest (3,0) -> misroute=1, payload delivered on m_data.
REQ-035 Reset mid-stream with 3 flits queued each way -> all outputs 0 and FIFOs empty; s_ready=1 on the first cycle after release.
